// File: rtl/rob_pkg.sv
// Shared widths and the reorder-buffer entry record used by rob_retire.
package rob_pkg;

    localparam int DATA_W = 32;
    localparam int PREG_W = 6;
    localparam int AREG_W = 5;

    typedef struct packed {
        logic              valid;
        logic              done;
        logic              wen;
        logic [AREG_W-1:0] rd;
        logic [PREG_W-1:0] pd;
        logic [PREG_W-1:0] old_pd;
        logic [DATA_W-1:0] value;
    } rob_entry_t;

endpackage

// File: rtl/rob_ptr.sv
// Ring-buffer pointer: IDX_W index bits plus one wrap bit, advanced by inc.
module rob_ptr #(
    parameter int IDX_W = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           inc,
    output logic [IDX_W:0] ptr
);

    // Index wraps DEPTH-1 -> 0 naturally and carries into the wrap bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (inc)
            ptr <= ptr + 1'b1;
    end

endmodule

// File: rtl/rob_retire.sv
// In-order retire end of the reorder buffer. Optional ROB_PERF_EN adds
// saturating retire and full-stall counters.
module rob_retire
    import rob_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alloc_valid,
    output logic              alloc_ready,
    input  logic              alloc_wen,
    input  logic [AREG_W-1:0] alloc_rd,
    input  logic [PREG_W-1:0] alloc_pd,
    input  logic [PREG_W-1:0] alloc_old_pd,
    output logic [IDX_W-1:0]  alloc_idx,
    input  logic              cmpl_valid,
    input  logic [IDX_W-1:0]  cmpl_idx,
    input  logic [DATA_W-1:0] cmpl_value,
    output logic              ret_valid,
    output logic              ret_wen,
    output logic [AREG_W-1:0] ret_rd,
    output logic [PREG_W-1:0] ret_pd,
    output logic [DATA_W-1:0] ret_value,
    output logic              free_valid,
    output logic [PREG_W-1:0] free_preg,
    output logic [IDX_W:0]    rob_count
`ifdef ROB_PERF_EN
    ,
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_full_stall
`endif
);

    logic [IDX_W:0]   head;
    logic [IDX_W:0]   tail;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             full;
    logic             empty;
    logic             alloc_fire;
    logic             cmpl_hit_head;
    logic             retire;
    logic [DATA_W-1:0] retire_value;
    rob_entry_t       head_entry;
    rob_entry_t       entries [DEPTH];
    logic [DEPTH-1:0] alloc_sel;
    logic [DEPTH-1:0] cmpl_sel;
    logic [DEPTH-1:0] retire_sel;

    rob_ptr #(.IDX_W(IDX_W)) u_head (.clk(clk), .rst(rst), .inc(retire),     .ptr(head));
    rob_ptr #(.IDX_W(IDX_W)) u_tail (.clk(clk), .rst(rst), .inc(alloc_fire), .ptr(tail));

    assign head_idx    = head[IDX_W-1:0];
    assign tail_idx    = tail[IDX_W-1:0];
    assign full        = (head_idx == tail_idx) && (head[IDX_W] != tail[IDX_W]);
    assign empty       = (head == tail);
    assign alloc_ready = !full;
    assign alloc_idx   = tail_idx;
    assign alloc_fire  = alloc_valid && !full;
    assign rob_count   = tail - head;

    // A completion landing on the head this cycle is bypassed straight into
    // the retire register, so retirement does not wait for done to settle.
    assign head_entry    = entries[head_idx];
    assign cmpl_hit_head = cmpl_valid && (cmpl_idx == head_idx) && head_entry.valid;
    assign retire        = !empty && (head_entry.done || cmpl_hit_head);
    assign retire_value  = cmpl_hit_head ? cmpl_value : head_entry.value;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            assign alloc_sel[gi]  = alloc_fire && (tail_idx == IDX_W'(gi));
            assign cmpl_sel[gi]   = cmpl_valid && (cmpl_idx == IDX_W'(gi)) && entries[gi].valid;
            assign retire_sel[gi] = retire && (head_idx == IDX_W'(gi));
        end
    endgenerate

    // The tail slot is always invalid when not full, so alloc never collides
    // with a completion or retire on the same entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                entries[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc_sel[i]) begin
                    entries[i] <= '{valid: 1'b1, done: 1'b0, wen: alloc_wen, rd: alloc_rd,
                                    pd: alloc_pd, old_pd: alloc_old_pd, value: '0};
                end else begin
                    if (cmpl_sel[i]) begin
                        entries[i].done  <= 1'b1;
                        entries[i].value <= cmpl_value;
                    end
                    if (retire_sel[i]) begin
                        entries[i].valid <= 1'b0;
                        entries[i].done  <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ret_valid  <= 1'b0;
            ret_wen    <= 1'b0;
            ret_rd     <= '0;
            ret_pd     <= '0;
            ret_value  <= '0;
            free_valid <= 1'b0;
            free_preg  <= '0;
        end else begin
            ret_valid  <= retire;
            free_valid <= retire && head_entry.wen && (head_entry.old_pd != head_entry.pd);
            if (retire) begin
                ret_wen   <= head_entry.wen;
                ret_rd    <= head_entry.rd;
                ret_pd    <= head_entry.pd;
                ret_value <= retire_value;
                free_preg <= head_entry.old_pd;
            end
        end
    end

`ifdef ROB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_retired    <= '0;
            perf_full_stall <= '0;
        end else begin
            if (retire && (perf_retired != '1))
                perf_retired <= perf_retired + 1'b1;
            if (alloc_valid && full && (perf_full_stall != '1))
                perf_full_stall <= perf_full_stall + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_rob_retire.sv
// Bench for rob_retire: directed scenarios plus random traffic against a
// queue-style ROB model (head index + occupancy count).
module tb_rob_retire;

    localparam int DEPTH = 16;
    localparam int IW    = 4;

    logic        clk;
    logic        rst;
    logic        alloc_valid;
    logic        alloc_ready;
    logic        alloc_wen;
    logic [4:0]  alloc_rd;
    logic [5:0]  alloc_pd;
    logic [5:0]  alloc_old_pd;
    logic [3:0]  alloc_idx;
    logic        cmpl_valid;
    logic [3:0]  cmpl_idx;
    logic [31:0] cmpl_value;
    logic        ret_valid;
    logic        ret_wen;
    logic [4:0]  ret_rd;
    logic [5:0]  ret_pd;
    logic [31:0] ret_value;
    logic        free_valid;
    logic [5:0]  free_preg;
    logic [4:0]  rob_count;
`ifdef ROB_PERF_EN
    logic [31:0] perf_retired;
    logic [31:0] perf_full_stall;
`endif

    rob_retire #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_wen(alloc_wen),
        .alloc_rd(alloc_rd), .alloc_pd(alloc_pd), .alloc_old_pd(alloc_old_pd),
        .alloc_idx(alloc_idx),
        .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx), .cmpl_value(cmpl_value),
        .ret_valid(ret_valid), .ret_wen(ret_wen), .ret_rd(ret_rd), .ret_pd(ret_pd),
        .ret_value(ret_value), .free_valid(free_valid), .free_preg(free_preg),
        .rob_count(rob_count)
`ifdef ROB_PERF_EN
        , .perf_retired(perf_retired), .perf_full_stall(perf_full_stall)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: tags live in [m_head, m_head+m_count) modulo DEPTH.
    bit          m_done [DEPTH];
    logic        m_wen  [DEPTH];
    logic [4:0]  m_rd   [DEPTH];
    logic [5:0]  m_pd   [DEPTH];
    logic [5:0]  m_opd  [DEPTH];
    logic [31:0] m_val  [DEPTH];
    int          m_head;
    int          m_count;
    int          m_ret;
    int          m_stall;

    logic        e_rv, e_wen, e_fv;
    logic [4:0]  e_rd;
    logic [5:0]  e_pd, e_fp;
    logic [31:0] e_val;

    function automatic bit live(int t);
        return ((t - m_head + DEPTH) % DEPTH) < m_count;
    endfunction

    function automatic int next_tag();
        return (m_head + m_count) % DEPTH;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) m_done[i] = 1'b0;
        m_head = 0; m_count = 0; m_ret = 0; m_stall = 0;
    endtask

    task automatic idle_inputs();
        alloc_valid = 1'b0; alloc_wen = 1'b0; alloc_rd = '0; alloc_pd = '0; alloc_old_pd = '0;
        cmpl_valid = 1'b0; cmpl_idx = '0; cmpl_value = '0;
    endtask

    // Drive one cycle of stimulus, predict the retire outputs, then advance the model.
    task automatic cycle(input bit av, input bit wen, input int rd, input int pd, input int opd,
                         input bit cv, input int cidx, input logic [31:0] cval);
        bit acc, hit;
        int tag, h;
        alloc_valid = av; alloc_wen = wen; alloc_rd = 5'(rd); alloc_pd = 6'(pd);
        alloc_old_pd = 6'(opd); cmpl_valid = cv; cmpl_idx = 4'(cidx); cmpl_value = cval;
        acc = av && (m_count < DEPTH);
        tag = next_tag();
        h   = m_head;
        hit = cv && (cidx == h) && (m_count > 0);
        e_rv  = (m_count > 0) && (m_done[h] || hit);
        e_wen = m_wen[h]; e_rd = m_rd[h]; e_pd = m_pd[h];
        e_val = hit ? cval : m_val[h];
        e_fv  = e_rv && m_wen[h] && (m_opd[h] != m_pd[h]);
        e_fp  = m_opd[h];
        @(posedge clk); #1;
        if (cv && live(cidx)) begin
            m_done[cidx] = 1'b1; m_val[cidx] = cval;
        end
        if (e_rv) begin
            $display("retire tag=%0d wen=%0d rd=%0d pd=%0d value=%h", h, e_wen, e_rd, e_pd, e_val);
            m_done[h] = 1'b0; m_head = (h + 1) % DEPTH; m_count--; m_ret++;
        end
        if (av && !acc) m_stall++;
        if (acc) begin
            m_wen[tag] = wen; m_rd[tag] = 5'(rd); m_pd[tag] = 6'(pd); m_opd[tag] = 6'(opd);
            m_done[tag] = 1'b0; m_count++;
        end
        idle_inputs();
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_clear();
        checks++;
        if (alloc_ready !== 1'b1 || rob_count !== 5'd0) begin
            errors++; $display("FAIL reset_state ready=%b count=%0d need ready=1 count=0", alloc_ready, rob_count);
        end
        checks++;
        if ({ret_valid, ret_wen, ret_rd, ret_pd, ret_value, free_valid, free_preg} !== 52'd0) begin
            errors++; $display("FAIL reset_outputs got=%h need 0",
                               {ret_valid, ret_wen, ret_rd, ret_pd, ret_value, free_valid, free_preg});
        end
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ret_valid !== 1'b0 || free_valid !== 1'b0 || rob_count !== 5'd0) begin
                errors++; $display("FAIL reset_idle cyc=%0d ret=%b free=%b count=%0d need 0/0/0",
                                   i, ret_valid, free_valid, rob_count);
            end
        end
    endtask

    task automatic test_single();
        do_reset();
        checks++;
        if (alloc_idx !== 4'd0) begin
            errors++; $display("FAIL single_idx got=%0d need 0", alloc_idx);
        end
        cycle(1, 1, 5, 33, 5, 0, 0, 0);
        checks++;
        if (rob_count !== 5'd1 || ret_valid !== 1'b0) begin
            errors++; $display("FAIL single_alloc count=%0d ret=%b need 1/0", rob_count, ret_valid);
        end
        cycle(0, 0, 0, 0, 0, 1, 0, 32'hDEAD);
        checks++;
        if ({ret_valid, ret_wen, ret_rd, ret_pd, ret_value, free_valid, free_preg} !==
            {1'b1, 1'b1, 5'd5, 6'd33, 32'hDEAD, 1'b1, 6'd5}) begin
            errors++; $display("FAIL single_retire got v=%b w=%b rd=%0d pd=%0d val=%h fv=%b fp=%0d need 1 1 5 33 0000dead 1 5",
                               ret_valid, ret_wen, ret_rd, ret_pd, ret_value, free_valid, free_preg);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ret_valid !== 1'b0 || free_valid !== 1'b0 || rob_count !== 5'd0) begin
            errors++; $display("FAIL single_pulse ret=%b free=%b count=%0d need 0/0/0", ret_valid, free_valid, rob_count);
        end
    endtask

    task automatic test_out_of_order();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (alloc_idx !== 4'(i)) begin
                errors++; $display("FAIL ooo_idx got=%0d need %0d", alloc_idx, i);
            end
            cycle(1, 1, i + 1, 40 + i, 10 + i, 0, 0, 0);
        end
        cycle(0, 0, 0, 0, 0, 1, 2, 32'h102);
        checks++;
        if (ret_valid !== 1'b0) begin
            errors++; $display("FAIL ooo_early2 ret=%b need 0", ret_valid);
        end
        cycle(0, 0, 0, 0, 0, 1, 1, 32'h101);
        checks++;
        if (ret_valid !== 1'b0) begin
            errors++; $display("FAIL ooo_early1 ret=%b need 0", ret_valid);
        end
        for (int k = 0; k < 3; k++) begin
            if (k == 0) cycle(0, 0, 0, 0, 0, 1, 0, 32'h100);
            else        cycle(0, 0, 0, 0, 0, 0, 0, 0);
            checks++;
            if (ret_valid !== 1'b1 || ret_pd !== 6'(40 + k) || ret_value !== 32'(32'h100 + k) ||
                free_preg !== 6'(10 + k)) begin
                errors++; $display("FAIL ooo_order k=%0d ret=%b pd=%0d val=%h fp=%0d need 1 %0d %h %0d",
                                   k, ret_valid, ret_pd, ret_value, free_preg, 40 + k, 32'h100 + k, 10 + k);
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ret_valid !== 1'b0 || rob_count !== 5'd0) begin
            errors++; $display("FAIL ooo_drain ret=%b count=%0d need 0/0", ret_valid, rob_count);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) cycle(1, 1, i, 32 + i, i, 0, 0, 0);
        checks++;
        if (alloc_ready !== 1'b0 || rob_count !== 5'd16) begin
            errors++; $display("FAIL full_state ready=%b count=%0d need 0/16", alloc_ready, rob_count);
        end
        cycle(1, 1, 9, 50, 9, 1, 0, 32'hBEEF);
        checks++;
        if (ret_valid !== 1'b1 || ret_pd !== 6'd32 || ret_value !== 32'hBEEF || rob_count !== 5'd15) begin
            errors++; $display("FAIL full_retire ret=%b pd=%0d val=%h count=%0d need 1 32 0000beef 15",
                               ret_valid, ret_pd, ret_value, rob_count);
        end
        checks++;
        if (alloc_ready !== 1'b1 || alloc_idx !== 4'd0) begin
            errors++; $display("FAIL full_reopen ready=%b idx=%0d need 1/0", alloc_ready, alloc_idx);
        end
        cycle(1, 1, 9, 50, 9, 0, 0, 0);
        checks++;
        if (rob_count !== 5'd16 || alloc_ready !== 1'b0 || alloc_idx !== 4'd1) begin
            errors++; $display("FAIL full_wrap count=%0d ready=%b idx=%0d need 16/0/1", rob_count, alloc_ready, alloc_idx);
        end
`ifdef ROB_PERF_EN
        checks++;
        if (perf_full_stall !== 32'(m_stall) || perf_retired !== 32'(m_ret)) begin
            errors++; $display("FAIL full_perf stall=%0d ret=%0d need %0d/%0d", perf_full_stall, perf_retired, m_stall, m_ret);
        end
`endif
    endtask

    task automatic test_invalid_cmpl();
        do_reset();
        cycle(0, 0, 0, 0, 0, 1, 7, 32'h77);
        checks++;
        if (rob_count !== 5'd0 || ret_valid !== 1'b0 || alloc_idx !== 4'd0) begin
            errors++; $display("FAIL inval_ignore count=%0d ret=%b idx=%0d need 0/0/0", rob_count, ret_valid, alloc_idx);
        end
        for (int i = 0; i < 8; i++) cycle(1, 1, i, 20 + i, i, 0, 0, 0);
        for (int i = 0; i < 7; i++) begin
            cycle(0, 0, 0, 0, 0, 1, i, 32'(32'hA0 + i));
            checks++;
            if (ret_valid !== e_rv || (e_rv && (ret_pd !== e_pd || ret_value !== e_val))) begin
                errors++; $display("FAIL inval_drain i=%0d ret=%b pd=%0d val=%h need %b %0d %h",
                                   i, ret_valid, ret_pd, ret_value, e_rv, e_pd, e_val);
            end
        end
        repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
        checks++;
        if (ret_valid !== 1'b0 || rob_count !== 5'd1) begin
            errors++; $display("FAIL inval_stuck ret=%b count=%0d need 0/1", ret_valid, rob_count);
        end
        cycle(0, 0, 0, 0, 0, 1, 7, 32'h7777);
        checks++;
        if (ret_valid !== 1'b1 || ret_pd !== 6'd27 || ret_value !== 32'h7777) begin
            errors++; $display("FAIL inval_own ret=%b pd=%0d val=%h need 1 27 00007777", ret_valid, ret_pd, ret_value);
        end
    endtask

    task automatic test_store_and_reset();
        do_reset();
        cycle(1, 0, 3, 12, 7, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 0, 32'h55);
        checks++;
        if (ret_valid !== 1'b1 || ret_wen !== 1'b0 || free_valid !== 1'b0 || ret_value !== 32'h55) begin
            errors++; $display("FAIL store_retire ret=%b wen=%b free=%b val=%h need 1 0 0 00000055",
                               ret_valid, ret_wen, free_valid, ret_value);
        end
        for (int i = 0; i < 5; i++) cycle(1, 1, i, 40 + i, i, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 1, 2, 32'h22);
        checks++;
        if (rob_count !== 5'd5) begin
            errors++; $display("FAIL store_live count=%0d need 5", rob_count);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (rob_count !== 5'd0 || alloc_ready !== 1'b1 || ret_valid !== 1'b0 || free_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_now count=%0d ready=%b ret=%b free=%b need 0 1 0 0",
                               rob_count, alloc_ready, ret_valid, free_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (ret_valid !== 1'b0 || free_valid !== 1'b0) begin
            errors++; $display("FAIL midrst_hold ret=%b free=%b need 0/0", ret_valid, free_valid);
        end
        rst = 1'b0;
        model_clear();
        repeat (3) cycle(0, 0, 0, 0, 0, 1, 2, 32'h1);
        checks++;
        if (ret_valid !== 1'b0 || rob_count !== 5'd0 || alloc_idx !== 4'd0) begin
            errors++; $display("FAIL midrst_after ret=%b count=%0d idx=%0d need 0/0/0", ret_valid, rob_count, alloc_idx);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            bit av, cv, wen;
            int cidx;
            av  = ($urandom % 3) != 0;
            cv  = ($urandom % 100) < ((n < 300) ? 30 : 75);
            wen = ($urandom % 4) != 0;
            if (m_count > 0 && ($urandom % 4) != 0)
                cidx = (m_head + int'($urandom % m_count)) % DEPTH;
            else
                cidx = int'($urandom % DEPTH);
            checks++;
            if (alloc_ready !== (m_count < DEPTH) || alloc_idx !== 4'(next_tag()) || rob_count !== 5'(m_count)) begin
                errors++; $display("FAIL rand_state n=%0d ready=%b idx=%0d count=%0d need %b %0d %0d",
                                   n, alloc_ready, alloc_idx, rob_count, m_count < DEPTH, next_tag(), m_count);
            end
            cycle(av, wen, int'($urandom % 32), int'($urandom % 64), int'($urandom % 64), cv, cidx, $urandom);
            checks++;
            if (ret_valid !== e_rv || free_valid !== e_fv ||
                (e_rv && {ret_wen, ret_rd, ret_pd, ret_value} !== {e_wen, e_rd, e_pd, e_val}) ||
                (e_fv && free_preg !== e_fp)) begin
                errors++; $display("FAIL rand_retire n=%0d got v=%b f=%b w=%b rd=%0d pd=%0d val=%h fp=%0d need %b %b %b %0d %0d %h %0d",
                                   n, ret_valid, free_valid, ret_wen, ret_rd, ret_pd, ret_value, free_preg,
                                   e_rv, e_fv, e_wen, e_rd, e_pd, e_val, e_fp);
            end
        end
`ifdef ROB_PERF_EN
        checks++;
        if (perf_retired !== 32'(m_ret) || perf_full_stall !== 32'(m_stall)) begin
            errors++; $display("FAIL rand_perf ret=%0d stall=%0d need %0d/%0d", perf_retired, perf_full_stall, m_ret, m_stall);
        end
`endif
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_clear();
        test_reset();
        test_single();
        test_out_of_order();
        test_full();
        test_invalid_cmpl();
        test_store_and_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
